// File: rtl/mac_pipe.sv
// mac_pipe: two-stage pipelined unsigned multiply-add / multiply-accumulate.
//
// Each accepted beat computes either a*b+c (mode 0) or accumulates a*b into
// an internal accumulator (mode 1; acc_clr restarts the accumulation).
// Valid/ready handshake on input and output. Both stages and the
// accumulator advance together on en = !out_valid || out_ready.
//
// Optional feature macro: MAC_SAT_EN
//   undefined : DATA_OUT wraps modulo 2^ACC_W, ovf flags the carry out.
//   defined   : on carry out, DATA_OUT saturates to all ones; in mode 1 the
//               accumulator also holds all ones until acc_clr or reset.
//
// Ports:
//   clk        in   1          rising-edge clock
//   reset      in   1          asynchronous, active-high
//   in_valid   in   1          input beat present
//   in_ready   out  1          beat accepted this cycle (equals en)
//   a, b       in   WIDTH      multiplicand / multiplier
//   c          in   2*WIDTH    addend (mode 0 only)
//   mode       in   1          0: a*b+c, 1: accumulate a*b
//   acc_clr    in   1          mode 1: this beat restarts accumulation
//   out_valid  out  1          DATA_OUT holds a result
//   out_ready  in   1          consumer takes the result this cycle
//   DATA_OUT   out  ACC_W      result
//   ovf        out  1          carry out of ACC_W occurred for this result
module mac_pipe #(
    parameter int WIDTH = 8,
    parameter int GUARD = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           a,
    input  logic [WIDTH-1:0]           b,
    input  logic [2*WIDTH-1:0]         c,
    input  logic                       mode,
    input  logic                       acc_clr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [2*WIDTH+GUARD-1:0]   DATA_OUT,
    output logic                       ovf
);

    localparam int ACC_W = 2*WIDTH + GUARD;
    localparam int EXT_W = ACC_W + 1 - 2*WIDTH;

    logic                 en;

    logic                 s1_valid_q, s1_valid_d;
    logic [2*WIDTH-1:0]   s1_prod_q,  s1_prod_d;
    logic [2*WIDTH-1:0]   s1_c_q,     s1_c_d;
    logic                 s1_mode_q,  s1_mode_d;
    logic                 s1_clr_q,   s1_clr_d;

    logic [ACC_W-1:0]     acc_q,      acc_d;
    logic                 out_valid_q, out_valid_d;
    logic [ACC_W-1:0]     data_q,     data_d;
    logic                 ovf_q,      ovf_d;

    logic [ACC_W:0]       prod_ext;
    logic [ACC_W:0]       c_ext;
    logic [ACC_W:0]       sum;
    logic [ACC_W-1:0]     result;

    assign en       = !out_valid_q || out_ready;
    assign in_ready = en;

    // Stage-2 arithmetic, one bit wider than the accumulator to catch the carry.
    always_comb begin
        prod_ext = {{EXT_W{1'b0}}, s1_prod_q};
        c_ext    = {{EXT_W{1'b0}}, s1_c_q};
        if (!s1_mode_q) begin
            sum = prod_ext + c_ext;
        end else if (s1_clr_q) begin
            sum = prod_ext;
        end else begin
            sum = {1'b0, acc_q} + prod_ext;
        end
`ifdef MAC_SAT_EN
        result = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
        result = sum[ACC_W-1:0];
`endif
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_prod_d   = s1_prod_q;
        s1_c_d      = s1_c_q;
        s1_mode_d   = s1_mode_q;
        s1_clr_d    = s1_clr_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        data_d      = data_q;
        ovf_d       = ovf_q;
        if (en) begin
            s1_valid_d  = in_valid;
            if (in_valid) begin
                s1_prod_d = a * b;
                s1_c_d    = c;
                s1_mode_d = mode;
                s1_clr_d  = acc_clr;
            end
            out_valid_d = s1_valid_q;
            // A bubble leaves the last result in place; only out_valid drops.
            if (s1_valid_q) begin
                data_d = result;
                ovf_d  = sum[ACC_W];
                if (s1_mode_q) begin
                    acc_d = result;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_prod_q   <= '0;
            s1_c_q      <= '0;
            s1_mode_q   <= 1'b0;
            s1_clr_q    <= 1'b0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            data_q      <= '0;
            ovf_q       <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_prod_q   <= s1_prod_d;
            s1_c_q      <= s1_c_d;
            s1_mode_q   <= s1_mode_d;
            s1_clr_q    <= s1_clr_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            data_q      <= data_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign DATA_OUT  = data_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_mac_pipe.sv
// Testbench for mac_pipe (WIDTH=8, GUARD=4, ACC_W=20).
// Reference model: results are computed with integer arithmetic when a beat
// is accepted and queued in order; every output transfer pops and compares.
module tb_mac_pipe;

    localparam int WIDTH = 8;
    localparam int GUARD = 4;
    localparam int ACC_W = 2*WIDTH + GUARD;
    localparam longint MOD  = 64'd1 << ACC_W;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [WIDTH-1:0]   a = '0;
    logic [WIDTH-1:0]   b = '0;
    logic [2*WIDTH-1:0] c = '0;
    logic               mode = 1'b0;
    logic               acc_clr = 1'b0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [ACC_W-1:0]   DATA_OUT;
    logic               ovf;

    mac_pipe #(.WIDTH(WIDTH), .GUARD(GUARD)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c(c), .mode(mode), .acc_clr(acc_clr),
        .out_valid(out_valid), .out_ready(out_ready),
        .DATA_OUT(DATA_OUT), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    // model state
    longint m_acc = 0;
    longint exp_data_q[$];
    bit     exp_ovf_q[$];
    longint got_data_q[$];
    bit     got_ovf_q[$];
    int     got_cyc_q[$];
    bit     prev_stall = 0;
    logic [ACC_W-1:0] prev_data;
    logic   prev_ovf;

    task automatic model_push(input longint ia, ib, ic, input bit im, icl);
        longint prod, sum, res;
        bit     o;
        prod = ia * ib;
        if (!im)      sum = prod + ic;
        else if (icl) sum = prod;
        else          sum = m_acc + prod;
        o = (sum >= MOD);
`ifdef MAC_SAT_EN
        res = o ? MOD - 1 : sum;
`else
        res = sum % MOD;
`endif
        if (im) m_acc = res;
        exp_data_q.push_back(res);
        exp_ovf_q.push_back(o);
    endtask

    task automatic model_reset();
        m_acc = 0;
        exp_data_q.delete();
        exp_ovf_q.delete();
        prev_stall = 0;
    endtask

    // One clock cycle: check hold, drive inputs, judge handshakes before the edge.
    task automatic step(input bit iv, input logic [7:0] ia, ib, input logic [15:0] ic,
                        input bit im, icl, ordy);
        longint e;
        bit     eo;
        @(negedge clk);
        cyc++;
        if (prev_stall) begin
            n_total++;
            if (out_valid !== 1'b1 || DATA_OUT !== prev_data || ovf !== prev_ovf)
                $display("FAIL hold: valid=%b data=%0d ovf=%b, required valid=1 data=%0d ovf=%b",
                         out_valid, DATA_OUT, ovf, prev_data, prev_ovf);
            else n_pass++;
        end
        in_valid = iv; a = ia; b = ib; c = ic; mode = im; acc_clr = icl; out_ready = ordy;
        #1;
        n_total++;
        if (in_ready !== (!out_valid || out_ready))
            $display("FAIL in_ready: got %b, required %b", in_ready, !out_valid || out_ready);
        else n_pass++;
        if (out_valid && out_ready) begin
            n_total++;
            if (exp_data_q.size() == 0) begin
                $display("FAIL unexpected_result: got data=%0d, required no result", DATA_OUT);
            end else begin
                e  = exp_data_q.pop_front();
                eo = exp_ovf_q.pop_front();
                if (DATA_OUT !== e[ACC_W-1:0] || ovf !== eo)
                    $display("FAIL result: got data=%0d ovf=%b, required data=%0d ovf=%b",
                             DATA_OUT, ovf, e, eo);
                else n_pass++;
            end
            got_data_q.push_back(longint'(DATA_OUT));
            got_ovf_q.push_back(ovf);
            got_cyc_q.push_back(cyc);
        end
        if (in_valid && in_ready) model_push(ia, ib, ic, im, icl);
        prev_stall = out_valid && !out_ready;
        prev_data  = DATA_OUT;
        prev_ovf   = ovf;
    endtask

    task automatic idle(input bit ordy);
        step(0, 0, 0, 0, 0, 0, ordy);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_data_q.size() != 0 && n < 20) begin
            idle(1);
            n++;
        end
        n_total++;
        if (exp_data_q.size() != 0)
            $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_data_q.size());
        else n_pass++;
    endtask

    task automatic clear_log();
        got_data_q.delete();
        got_ovf_q.delete();
        got_cyc_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_total++;
        if (out_valid !== 1'b0 || DATA_OUT !== '0 || ovf !== 1'b0)
            $display("FAIL reset_outputs: valid=%b data=%0d ovf=%b, required 0/0/0",
                     out_valid, DATA_OUT, ovf);
        else n_pass++;
        reset = 1'b0;
        model_reset();
        #1;
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        else n_pass++;
    endtask

    task automatic test_mode0_max();
        int n0;
        clear_log();
        step(1, 255, 255, 16'hFFFF, 0, 0, 1);
        idle(1);
        n_total++;
        if (got_data_q.size() != 0) $display("FAIL latency_early: got %0d results, required 0", got_data_q.size());
        else n_pass++;
        n0 = got_data_q.size();
        idle(1);
        n_total++;
        if (got_data_q.size() != n0 + 1 || got_data_q[0] != 130560 || got_ovf_q[0] != 0)
            $display("FAIL mode0_max: got %0d results (first=%0d), required one result 130560 ovf=0",
                     got_data_q.size(), got_data_q.size() ? got_data_q[0] : -1);
        else n_pass++;
    endtask

    task automatic test_accumulate();
        clear_log();
        for (int i = 0; i < 4; i++) step(1, 3, 5, 16'(i * 77), 1, i == 0, 1);
        drain();
        n_total++;
        if (got_data_q.size() != 4)
            $display("FAIL acc_count: got %0d results, required 4", got_data_q.size());
        else begin
            bit ok = 1;
            for (int i = 0; i < 4; i++) begin
                if (got_data_q[i] != 15 * (i + 1)) ok = 0;
                if (i > 0 && got_cyc_q[i] != got_cyc_q[i-1] + 1) ok = 0;
            end
            if (!ok) $display("FAIL acc_seq: got %0d,%0d,%0d,%0d required 15,30,45,60 consecutive",
                              got_data_q[0], got_data_q[1], got_data_q[2], got_data_q[3]);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        int sent = 0;
        clear_log();
        for (int i = 0; i < 3; i++) begin
            step(1, 8'($urandom), 8'($urandom), 16'($urandom), 0, 0, 1);
            sent++;
        end
        for (int i = 0; i < 3; i++) begin
            step(1, 8'($urandom), 8'($urandom), 16'($urandom), 0, 0, 0);
            n_total++;
            if (in_ready !== 1'b0) $display("FAIL stall_in_ready: got %b, required 0", in_ready);
            else n_pass++;
        end
        for (int i = 0; i < 3; i++) begin
            step(1, 8'($urandom), 8'($urandom), 16'($urandom), 0, 0, 1);
            if (i > 0) sent++;
        end
        // the first release cycle re-presents a beat that was refused while stalled
        sent++;
        drain();
        n_total++;
        if (got_data_q.size() != sent)
            $display("FAIL b2b_count: got %0d results, required %0d", got_data_q.size(), sent);
        else n_pass++;
    endtask

    task automatic test_overflow();
        clear_log();
        for (int i = 0; i < 17; i++) step(1, 255, 255, 0, 1, i == 0, 1);
        drain();
        n_total++;
        if (got_data_q.size() != 17)
            $display("FAIL ovf_count: got %0d results, required 17", got_data_q.size());
        else begin
            longint exp17;
`ifdef MAC_SAT_EN
            exp17 = 1048575;
`else
            exp17 = 56849;
`endif
            if (got_data_q[15] != 1040400 || got_ovf_q[15] != 0)
                $display("FAIL ovf_16th: got %0d ovf=%b, required 1040400 ovf=0", got_data_q[15], got_ovf_q[15]);
            else n_pass++;
            n_total++;
            if (got_data_q[16] != exp17 || got_ovf_q[16] != 1)
                $display("FAIL ovf_17th: got %0d ovf=%b, required %0d ovf=1", got_data_q[16], got_ovf_q[16], exp17);
            else n_pass++;
        end
    endtask

    task automatic test_async_reset();
        clear_log();
        for (int i = 0; i < 4; i++) step(1, 8'($urandom), 8'($urandom), 0, 1, i == 0, 1);
        @(negedge clk);
        in_valid = 0;
        n_total++;
        if (out_valid !== 1'b1) $display("FAIL pre_reset_valid: got %b, required 1", out_valid);
        else n_pass++;
        #2;
        reset = 1'b1;
        #1;
        n_total++;
        if (out_valid !== 1'b0 || DATA_OUT !== '0 || ovf !== 1'b0)
            $display("FAIL async_reset: valid=%b data=%0d ovf=%b, required 0/0/0", out_valid, DATA_OUT, ovf);
        else n_pass++;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
        clear_log();
        step(1, 2, 2, 0, 1, 0, 1);
        drain();
        n_total++;
        if (got_data_q.size() != 1 || got_data_q[0] != 4)
            $display("FAIL post_reset_acc: got %0d results (first=%0d), required one result 4",
                     got_data_q.size(), got_data_q.size() ? got_data_q[0] : -1);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom), 16'($urandom),
                 $urandom_range(0, 1), $urandom_range(0, 5) == 0, $urandom_range(0, 3) != 0);
        drain();
    endtask

    initial begin
        test_reset();
        test_mode0_max();
        test_accumulate();
        test_back_to_back();
        test_overflow();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule
